// File: rtl/rgb_to_yuv_pkg.sv
// rtl/rgb_to_yuv_pkg.sv - shared types and constants for the RGB to YUV 4:2:2 encoder
package rgb_yuv_pkg;

  typedef enum logic [2:0] {
    S_P0,
    S_P1,
    S_U,
    S_Y1,
    S_V,
    S_Y2
  } state_t;

  localparam int Y_CR = 75;
  localparam int Y_CG = 161;
  localparam int Y_CB = 20;

  localparam int U_CR = -37;
  localparam int U_CG = -81;
  localparam int U_CB = 118;

  localparam int V_CR = 112;
  localparam int V_CG = -99;
  localparam int V_CB = -13;

  localparam int RND_Y = 128;
  localparam int RND_C = 256;

  localparam int SH_Y = 8;
  localparam int SH_C = 9;

  function automatic logic is_out_state(input state_t s);
    return (s == S_U) || (s == S_Y1) || (s == S_V) || (s == S_Y2);
  endfunction

endpackage

// File: rtl/rgb_to_yuv_if.sv
// rtl/rgb_to_yuv_if.sv - pixel input / byte output bundle of the encoder
interface rgb_to_yuv_if;

  logic        in_en;
  logic [23:0] rgb_in;
  logic        busy;
  logic        out_valid;
  logic [7:0]  yuv_out;

  modport master (
    output in_en,
    output rgb_in,
    input  busy,
    input  out_valid,
    input  yuv_out
  );

  modport slave (
    input  in_en,
    input  rgb_in,
    output busy,
    output out_valid,
    output yuv_out
  );

endinterface

// File: rtl/rgb_to_yuv_matrix.sv
// rtl/rgb_to_yuv_matrix.sv - one row of the colour matrix: dot product, round, shift, clamp
module rgb_yuv_matrix #(
  parameter int COEF_W = 9,
  parameter int ACC_W  = 19
) (
  input  logic [8:0]               r_sum,
  input  logic [8:0]               g_sum,
  input  logic [8:0]               b_sum,
  input  logic signed [COEF_W-1:0] c_r,
  input  logic signed [COEF_W-1:0] c_g,
  input  logic signed [COEF_W-1:0] c_b,
  input  logic signed [ACC_W-1:0]  rnd,
  input  logic [3:0]               shamt,
  input  logic                     is_signed,
  output logic [7:0]               res
);

  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-128);
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] ZERO  = '0;

  logic signed [ACC_W-1:0] r_ext, g_ext, b_ext;
  logic signed [ACC_W-1:0] cr_ext, cg_ext, cb_ext;
  logic signed [ACC_W-1:0] acc, shifted;

  // Everything is widened to ACC_W before multiplying so no partial sum is truncated.
  always_comb begin
    r_ext  = $signed({{(ACC_W-9){1'b0}}, r_sum});
    g_ext  = $signed({{(ACC_W-9){1'b0}}, g_sum});
    b_ext  = $signed({{(ACC_W-9){1'b0}}, b_sum});
    cr_ext = $signed({{(ACC_W-COEF_W){c_r[COEF_W-1]}}, c_r});
    cg_ext = $signed({{(ACC_W-COEF_W){c_g[COEF_W-1]}}, c_g});
    cb_ext = $signed({{(ACC_W-COEF_W){c_b[COEF_W-1]}}, c_b});
    acc     = r_ext * cr_ext + g_ext * cg_ext + b_ext * cb_ext + rnd;
    shifted = acc >>> shamt;
  end

  always_comb begin
    res = shifted[7:0];
    if (is_signed) begin
      if (shifted > S_MAX) begin
        res = 8'h7f;
      end else if (shifted < S_MIN) begin
        res = 8'h80;
      end
    end else begin
      if (shifted > U_MAX) begin
        res = 8'hff;
      end else if (shifted < ZERO) begin
        res = 8'h00;
      end
    end
  end

endmodule

// File: rtl/rgb_to_yuv.sv
// rtl/rgb_to_yuv.sv - accepts an RGB pixel pair and emits U, Y1, V, Y2 bytes
module rgb_to_yuv
  import rgb_yuv_pkg::*;
#(
  parameter int COEF_W = 9,
  parameter int ACC_W  = 19
) (
  input  logic          clk,
  input  logic          reset,
  rgb_to_yuv_if.slave   bus
);

  state_t      state, state_nxt;
  logic [23:0] pix0, pix1;

  logic [8:0]               r_sum, g_sum, b_sum;
  logic signed [COEF_W-1:0] c_r, c_g, c_b;
  logic signed [ACC_W-1:0]  rnd;
  logic [3:0]               shamt;
  logic                     is_chroma;
  logic                     out_active;
  logic [7:0]               mat_res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_P0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_P0:    if (bus.in_en) state_nxt = S_P1;
      S_P1:    if (bus.in_en) state_nxt = S_U;
      S_U:     state_nxt = S_Y1;
      S_Y1:    state_nxt = S_V;
      S_V:     state_nxt = S_Y2;
      S_Y2:    state_nxt = S_P0;
      default: state_nxt = S_P0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix0 <= '0;
      pix1 <= '0;
    end else begin
      if (state == S_P0 && bus.in_en) pix0 <= bus.rgb_in;
      if (state == S_P1 && bus.in_en) pix1 <= bus.rgb_in;
    end
  end

  // Operand mux: the single matrix instance serves all four output bytes.
  always_comb begin
    r_sum     = {1'b0, pix0[23:16]};
    g_sum     = {1'b0, pix0[15:8]};
    b_sum     = {1'b0, pix0[7:0]};
    c_r       = COEF_W'(Y_CR);
    c_g       = COEF_W'(Y_CG);
    c_b       = COEF_W'(Y_CB);
    rnd       = ACC_W'(RND_Y);
    shamt     = 4'(SH_Y);
    is_chroma = 1'b0;
    case (state)
      S_U, S_V: begin
        r_sum     = {1'b0, pix0[23:16]} + {1'b0, pix1[23:16]};
        g_sum     = {1'b0, pix0[15:8]}  + {1'b0, pix1[15:8]};
        b_sum     = {1'b0, pix0[7:0]}   + {1'b0, pix1[7:0]};
        rnd       = ACC_W'(RND_C);
        shamt     = 4'(SH_C);
        is_chroma = 1'b1;
        if (state == S_U) begin
          c_r = COEF_W'(U_CR);
          c_g = COEF_W'(U_CG);
          c_b = COEF_W'(U_CB);
        end else begin
          c_r = COEF_W'(V_CR);
          c_g = COEF_W'(V_CG);
          c_b = COEF_W'(V_CB);
        end
      end
      S_Y2: begin
        r_sum = {1'b0, pix1[23:16]};
        g_sum = {1'b0, pix1[15:8]};
        b_sum = {1'b0, pix1[7:0]};
      end
      default: begin
      end
    endcase
  end

  rgb_yuv_matrix #(
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_matrix (
    .r_sum     (r_sum),
    .g_sum     (g_sum),
    .b_sum     (b_sum),
    .c_r       (c_r),
    .c_g       (c_g),
    .c_b       (c_b),
    .rnd       (rnd),
    .shamt     (shamt),
    .is_signed (is_chroma),
    .res       (mat_res)
  );

  // Handshake outputs depend on the registered state only.
  always_comb begin
    out_active    = is_out_state(state);
    bus.busy      = out_active;
    bus.out_valid = out_active;
    bus.yuv_out   = out_active ? mat_res : 8'h00;
  end

endmodule

// File: tb/tb_rgb_to_yuv.sv
// tb/tb_rgb_to_yuv.sv - self-checking bench for rgb_to_yuv
module tb_rgb_to_yuv;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  rgb_to_yuv_if bus ();

  rgb_to_yuv #(.COEF_W(9), .ACC_W(19)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_y(input logic [23:0] p);
    int y;
    y = (75 * int'(p[23:16]) + 161 * int'(p[15:8]) + 20 * int'(p[7:0]) + 128) >> 8;
    if (y > 255) y = 255;
    if (y < 0) y = 0;
    return y[7:0];
  endfunction

  function automatic logic [7:0] ref_c(input logic [23:0] p0, input logic [23:0] p1,
                                       input int cr, input int cg, input int cb);
    int rs, gs, bs, q;
    rs = int'(p0[23:16]) + int'(p1[23:16]);
    gs = int'(p0[15:8])  + int'(p1[15:8]);
    bs = int'(p0[7:0])   + int'(p1[7:0]);
    q  = (cr * rs + cg * gs + cb * bs + 256) >>> 9;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  function automatic logic [31:0] ref_burst(input logic [23:0] p0, input logic [23:0] p1);
    return {ref_c(p0, p1, -37, -81, 118), ref_y(p0), ref_c(p0, p1, 112, -99, -13), ref_y(p1)};
  endfunction

  // Starts at a falling edge with the DUT idle; ends on the falling edge after Y2.
  task automatic drive_pair(input logic [23:0] p0, input logic [23:0] p1, input int gap,
                            input bit noisy, input bit no_wait,
                            output logic [31:0] got, output int vcnt, output int stall_busy,
                            output logic busy_after, output int start_cyc);
    got = '0;
    vcnt = 0;
    stall_busy = 0;
    if (!no_wait) @(negedge clk);
    start_cyc = cyc;
    bus.in_en = 1'b1;
    bus.rgb_in = p0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.in_en = 1'b0;
      bus.rgb_in = noisy ? 24'($urandom) : 24'h0;
      if (bus.busy) stall_busy++;
    end
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.rgb_in = p1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (noisy) begin
        bus.in_en = 1'($urandom);
        bus.rgb_in = 24'($urandom);
      end else begin
        bus.in_en = 1'b0;
      end
      if (bus.out_valid) vcnt++;
      got = {got[23:0], bus.yuv_out};
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    busy_after = bus.busy;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.out_valid, bus.yuv_out} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b valid=%b yuv=%h, required 0 0 00",
               bus.busy, bus.out_valid, bus.yuv_out);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_directed();
    logic [23:0] p[4];
    logic [31:0] e[4];
    logic [31:0] got;
    int vcnt, sb, sc;
    logic ba;
    p[0] = 24'hFFFFFF; e[0] = 32'h00FF00FF;
    p[1] = 24'hFF0000; e[1] = 32'hDB4B704B;
    p[2] = 24'h0000FF; e[2] = 32'h7614F314;
    p[3] = 24'h000000; e[3] = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      drive_pair(p[i], p[i], 0, 1'b0, 1'b0, got, vcnt, sb, ba, sc);
      n_tests++;
      if (got !== e[i] || vcnt != 4 || ba !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_%0d: got bytes=%h valid_cycles=%0d busy_after=%b, required %h 4 0",
                 i, got, vcnt, ba, e[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] got;
    int vcnt, sb, sc;
    logic ba;
    drive_pair(24'hFF0000, 24'h0000FF, 5, 1'b1, 1'b0, got, vcnt, sb, ba, sc);
    n_tests++;
    if (got !== ref_burst(24'hFF0000, 24'h0000FF) || vcnt != 4) begin
      n_fail++;
      $display("FAIL stall_bytes: got %h valid_cycles=%0d, required %h 4",
               got, vcnt, ref_burst(24'hFF0000, 24'h0000FF));
    end
    n_tests++;
    if (sb != 0) begin
      n_fail++;
      $display("FAIL stall_busy: got %0d busy cycles during stall, required 0", sb);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] p0, p1;
    logic [31:0] got;
    int vcnt, sb, sc, prev_sc;
    logic ba;
    prev_sc = 0;
    for (int i = 0; i < 4; i++) begin
      p0 = 24'($urandom);
      p1 = 24'($urandom);
      drive_pair(p0, p1, 0, 1'b0, (i != 0), got, vcnt, sb, ba, sc);
      n_tests++;
      if (got !== ref_burst(p0, p1)) begin
        n_fail++;
        $display("FAIL b2b_bytes_%0d: got %h, required %h", i, got, ref_burst(p0, p1));
      end
      if (i != 0) begin
        n_tests++;
        if (sc - prev_sc != 6) begin
          n_fail++;
          $display("FAIL b2b_period_%0d: got %0d cycles, required 6", i, sc - prev_sc);
        end
      end
      prev_sc = sc;
    end
  endtask

  task automatic test_reset_burst();
    logic [31:0] got;
    int vcnt, sb, sc, resumed;
    logic ba;
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.rgb_in = 24'hFF0000;
    @(negedge clk);
    @(negedge clk);
    bus.in_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.yuv_out !== 8'h70) begin
      n_fail++;
      $display("FAIL burst_before_reset: got valid=%b yuv=%h, required 1 70",
               bus.out_valid, bus.yuv_out);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.out_valid, bus.yuv_out} !== 10'h0) begin
      n_fail++;
      $display("FAIL async_reset_abort: got busy=%b valid=%b yuv=%h, required 0 0 00",
               bus.busy, bus.out_valid, bus.yuv_out);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    resumed = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) resumed++;
    end
    n_tests++;
    if (resumed != 0) begin
      n_fail++;
      $display("FAIL no_resume: got %0d valid cycles after release, required 0", resumed);
    end
    drive_pair(24'h000000, 24'h000000, 0, 1'b0, 1'b0, got, vcnt, sb, ba, sc);
    n_tests++;
    if (got !== 32'h00000000 || vcnt != 4) begin
      n_fail++;
      $display("FAIL black_after_reset: got %h valid_cycles=%0d, required 00000000 4", got, vcnt);
    end
  endtask

  task automatic test_random();
    logic [23:0] p0, p1;
    logic [31:0] got;
    int vcnt, sb, sc, bad_hs;
    logic ba;
    bad_hs = 0;
    for (int i = 0; i < 1000; i++) begin
      p0 = 24'($urandom);
      p1 = 24'($urandom);
      drive_pair(p0, p1, $urandom_range(0, 3), 1'b1, ($urandom_range(0, 1) == 1), got, vcnt, sb, ba, sc);
      if (vcnt != 4 || ba !== 1'b0 || sb != 0) bad_hs++;
      n_tests++;
      if (got !== ref_burst(p0, p1)) begin
        n_fail++;
        $display("FAIL random_pair_%0d: in %h %h got %h, required %h", i, p0, p1, got, ref_burst(p0, p1));
      end
    end
    n_tests++;
    if (bad_hs != 0) begin
      n_fail++;
      $display("FAIL random_handshake: got %0d bad bursts, required 0", bad_hs);
    end
  endtask

  task automatic test_roundtrip();
    logic [23:0] p;
    logic [31:0] got;
    logic signed [7:0] ub, vb;
    int vcnt, sb, sc, worst_bad;
    logic ba;
    real y, u, v, rr, gg, bb;
    real dec[3];
    real org[3];
    for (int i = 0; i < 100; i++) begin
      p = 24'($urandom);
      drive_pair(p, p, 0, 1'b0, 1'b0, got, vcnt, sb, ba, sc);
      ub = got[31:24];
      vb = got[15:8];
      y  = real'(int'(got[23:16]));
      u  = real'(int'(ub));
      v  = real'(int'(vb));
      rr = y + (113.0 * u + 20618.0 * v) / 12735.0;
      gg = y + (-3215.0 * u - 9590.0 * v) / 12735.0;
      bb = y + (25457.0 * u - 118.0 * v) / 12735.0;
      dec[0] = rr; dec[1] = gg; dec[2] = bb;
      org[0] = real'(int'(p[23:16]));
      org[1] = real'(int'(p[15:8]));
      org[2] = real'(int'(p[7:0]));
      worst_bad = 0;
      for (int c = 0; c < 3; c++) begin
        if (dec[c] < 0.0) dec[c] = 0.0;
        if (dec[c] > 255.0) dec[c] = 255.0;
        if (dec[c] - org[c] > 3.0 || org[c] - dec[c] > 3.0) worst_bad++;
      end
      n_tests++;
      if (worst_bad != 0) begin
        n_fail++;
        $display("FAIL roundtrip_%0d: pixel %h decoded to %0f %0f %0f, required within 3 LSB",
                 i, p, dec[0], dec[1], dec[2]);
      end
    end
  endtask

  initial begin
    cyc = 0;
    n_tests = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.in_en = 1'b0;
    bus.rgb_in = 24'h0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_burst();
    test_random();
    test_roundtrip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
